// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and address helpers for the fetch/data memory arbiter.
package mem_arb_pkg;

  // Who owns the read response that appears in the current cycle.
  typedef enum logic [2:0] {
    RESP_NONE    = 3'd0,
    RESP_IF      = 3'd1,
    RESP_D       = 3'd2,
    RESP_IF_ZERO = 3'd3,
    RESP_D_ZERO  = 3'd4
  } resp_owner_e;

  // Full 30-bit word index plus its range flag; callers slice the index
  // down to the memory's index width once the range has been checked.
  typedef struct packed {
    logic        in_range;
    logic [29:0] idx;
  } addr_map_t;

  // Byte address to word index relative to base; bits [1:0] are dropped.
  function automatic addr_map_t addr_to_idx(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] words);
    addr_map_t m;
    m.idx      = 30'((addr - base) >> 2);
    m.in_range = ({2'b00, m.idx} < words);
    return m;
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Request/response and memory-side signals of the shared memory arbiter.
// master: the environment (CPU ports and memory array); slave: the arbiter.
interface shared_mem_arbiter_if #(
  parameter int IDX_W = 14
);
  logic             if_req_valid;
  logic [31:0]      if_req_addr;
  logic             if_req_ready;
  logic             if_resp_valid;
  logic [31:0]      if_resp_data;

  logic             d_req_valid;
  logic             d_req_we;
  logic [31:0]      d_req_addr;
  logic [31:0]      d_req_data;
  logic             d_req_ready;
  logic             d_resp_valid;
  logic [31:0]      d_resp_data;

  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_data,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_en, mem_we, mem_idx, mem_wdata
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_data,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Arbitrates one single-ported word memory between instruction fetch and
// data access. Data wins ties unless fetch has been denied STARVE_LIMIT
// cycles in a row. Reads return one cycle after the grant.
//
// resp_q       | meaning
// RESP_NONE    | no response this cycle
// RESP_IF      | fetch response, data from mem_rdata
// RESP_D       | load response, data from mem_rdata
// RESP_IF_ZERO | out-of-range fetch, returns 0
// RESP_D_ZERO  | out-of-range load, returns 0
module shared_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          MEM_WORDS    = 16384,
  parameter logic [31:0] MEM_BASE     = 32'h0,
  parameter int          STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  shared_mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  addr_map_t       if_map;
  addr_map_t       d_map;
  addr_map_t       sel_map;
  logic            starved;
  logic            grant_if;
  logic            grant_d;
  logic            sel_en;
  logic            unused_idx_hi;
  logic [CNT_W-1:0] starve_cnt;
  resp_owner_e     resp_q;
  resp_owner_e     resp_nxt;

  assign if_map = addr_to_idx(bus.if_req_addr, MEM_BASE, 32'(MEM_WORDS));
  assign d_map  = addr_to_idx(bus.d_req_addr, MEM_BASE, 32'(MEM_WORDS));

  // Grants are forced low during reset so every output reads 0 at once.
  assign starved  = (starve_cnt == CNT_MAX);
  assign grant_d  = !reset && bus.d_req_valid && !(bus.if_req_valid && starved);
  assign grant_if = !reset && bus.if_req_valid && !grant_d;

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;

  // Out-of-range accesses are still granted but never touch the memory.
  assign sel_map       = grant_d ? d_map : if_map;
  assign sel_en        = (grant_d || grant_if) && sel_map.in_range;
  assign unused_idx_hi = ^sel_map.idx[29:IDX_W];

  assign bus.mem_en    = sel_en;
  assign bus.mem_we    = sel_en && grant_d && bus.d_req_we;
  assign bus.mem_idx   = sel_en ? sel_map.idx[IDX_W-1:0] : '0;
  assign bus.mem_wdata = (sel_en && grant_d && bus.d_req_we) ? bus.d_req_data : '0;

  // Decide who owns next cycle's read response; stores produce none.
  always_comb begin
    resp_nxt = RESP_NONE;
    if (grant_d) begin
      if (!bus.d_req_we) begin
        resp_nxt = d_map.in_range ? RESP_D : RESP_D_ZERO;
      end
    end else if (grant_if) begin
      resp_nxt = if_map.in_range ? RESP_IF : RESP_IF_ZERO;
    end
  end

  // Response owner register; reset discards any response in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_nxt;
    end
  end

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.if_req_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.if_resp_valid = (resp_q == RESP_IF) || (resp_q == RESP_IF_ZERO);
  assign bus.if_resp_data  = (resp_q == RESP_IF) ? bus.mem_rdata : '0;
  assign bus.d_resp_valid  = (resp_q == RESP_D) || (resp_q == RESP_D_ZERO);
  assign bus.d_resp_data   = (resp_q == RESP_D) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: a behavioural one-cycle memory, a shadow
// model of its contents, a grant/starvation model and response queues.
module tb_shared_mem_arbiter;

  localparam int          MEM_WORDS    = 16384;
  localparam int          IDX_W        = 14;
  localparam logic [31:0] MEM_BASE     = 32'h0;
  localparam int          STARVE_LIMIT = 4;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic load_ram;

  shared_mem_arbiter_if #(.IDX_W(IDX_W)) bus ();

  shared_mem_arbiter #(
    .MEM_WORDS   (MEM_WORDS),
    .MEM_BASE    (MEM_BASE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] ram    [MEM_WORDS];
  logic [31:0] shadow [MEM_WORDS];
  exp_t        if_q[$];
  exp_t        d_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          starve_m = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'h0000_0013 : (32'hA500_0000 | 32'(i));
  endfunction

  // Memory array: registered read, write on mem_we.
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_word(i);
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_idx] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_idx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic addr_model(input logic [31:0] addr, output logic in_r, output int idx);
    logic [31:0] w;
    w    = (addr - MEM_BASE) >> 2;
    in_r = (w < 32'(MEM_WORDS));
    idx  = in_r ? int'(w) : 0;
  endtask

  task automatic check_resp();
    logic        ev;
    logic [31:0] ed;
    ev = (if_q.size() > 0) && (if_q[0].cyc == cyc);
    ed = ev ? if_q[0].data : 32'h0;
    chk("if_resp_valid", {31'h0, bus.if_resp_valid}, {31'h0, ev});
    chk("if_resp_data", bus.if_resp_data, ed);
    if (ev) void'(if_q.pop_front());
    ev = (d_q.size() > 0) && (d_q[0].cyc == cyc);
    ed = ev ? d_q[0].data : 32'h0;
    chk("d_resp_valid", {31'h0, bus.d_resp_valid}, {31'h0, ev});
    chk("d_resp_data", bus.d_resp_data, ed);
    if (ev) void'(d_q.pop_front());
  endtask

  // One bus cycle: drive at the falling edge, check just after, update model.
  task automatic step(input logic iv, input logic [31:0] ia,
                      input logic dv, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd, output logic gi, output logic gd);
    logic in_i, in_d, exp_en, exp_we;
    int   idx_i, idx_d, exp_idx;
    @(negedge clk);
    cyc++;
    bus.if_req_valid = iv;
    bus.if_req_addr  = ia;
    bus.d_req_valid  = dv;
    bus.d_req_we     = dwe;
    bus.d_req_addr   = da;
    bus.d_req_data   = dwd;
    #2;
    addr_model(ia, in_i, idx_i);
    addr_model(da, in_d, idx_d);
    gd = dv && !(iv && starve_m == STARVE_LIMIT);
    gi = iv && !gd;
    chk("if_req_ready", {31'h0, bus.if_req_ready}, {31'h0, gi});
    chk("d_req_ready", {31'h0, bus.d_req_ready}, {31'h0, gd});
    check_resp();
    exp_en  = (gd && in_d) || (gi && in_i);
    exp_we  = gd && in_d && dwe;
    exp_idx = gd ? idx_d : idx_i;
    chk("mem_en", {31'h0, bus.mem_en}, {31'h0, exp_en});
    chk("mem_we", {31'h0, bus.mem_we}, {31'h0, exp_we});
    if (exp_en) chk("mem_idx", 32'(bus.mem_idx), 32'(exp_idx));
    if (exp_we) chk("mem_wdata", bus.mem_wdata, dwd);
    if (gi) if_q.push_back('{cyc + 1, in_i ? shadow[idx_i] : 32'h0});
    if (gd) begin
      if (dwe) begin
        if (in_d) shadow[idx_d] = dwd;
      end else begin
        d_q.push_back('{cyc + 1, in_d ? shadow[idx_d] : 32'h0});
      end
    end
    if (!iv || gi) starve_m = 0;
    else if (starve_m < STARVE_LIMIT) starve_m++;
  endtask

  task automatic idle(input int n);
    logic gi, gd;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_if_ready"}, {31'h0, bus.if_req_ready}, 32'h0);
    chk({tag, "_d_ready"}, {31'h0, bus.d_req_ready}, 32'h0);
    chk({tag, "_mem_en"}, {31'h0, bus.mem_en}, 32'h0);
    chk({tag, "_if_resp_valid"}, {31'h0, bus.if_resp_valid}, 32'h0);
    chk({tag, "_d_resp_valid"}, {31'h0, bus.d_resp_valid}, 32'h0);
  endtask

  initial begin
    logic        gi, gd;
    logic        if_pend, d_pend, d_we_r;
    logic [31:0] if_addr_r, d_addr_r, d_data_r;
    int          fetch_grants;

    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = init_word(i);
    reset            = 1'b1;
    load_ram         = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = 32'h0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_we     = 1'b0;
    bus.d_req_addr   = 32'h0;
    bus.d_req_data   = 32'h0;
    #3;
    check_quiet("reset");
    @(posedge clk);
    #1 load_ram = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Lone fetch of mem[64].
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    idle(1);

    // Simultaneous fetch and load: data first, fetch next cycle.
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, gi, gd);
    chk("tie_data_first", {31'h0, gd}, 32'h1);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    idle(2);

    // Continuous data stream against a waiting fetch.
    fetch_grants = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 32'h40, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, gi, gd);
      if (gi) fetch_grants++;
    end
    chk("starve_fetch_grants", 32'(fetch_grants), 32'd3);
    idle(2);

    // Store then immediate load of the same word.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hDEAD_BEEF, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, gi, gd);
    idle(1);

    // Out-of-range load, store and fetch.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, gi, gd);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0002_0000, 32'h1234_5678, gi, gd);
    step(1'b1, 32'h0001_0004, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    idle(2);

    // Random mixed traffic; each requester holds its request until granted.
    if_pend = 1'b0;
    d_pend  = 1'b0;
    if_addr_r = 32'h0; d_addr_r = 32'h0; d_data_r = 32'h0; d_we_r = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!if_pend) begin
        if_pend   = ($urandom_range(0, 3) != 0);
        if_addr_r = 32'($urandom_range(0, MEM_WORDS + 15)) << 2;
      end
      if (!d_pend) begin
        d_pend   = ($urandom_range(0, 3) != 0);
        d_we_r   = ($urandom_range(0, 2) == 0);
        d_addr_r = 32'($urandom_range(0, MEM_WORDS + 15)) << 2;
        d_data_r = $urandom;
      end
      step(if_pend, if_addr_r, d_pend, d_we_r, d_addr_r, d_data_r, gi, gd);
      if (gi) if_pend = 1'b0;
      if (gd) d_pend = 1'b0;
    end
    idle(2);

    // Reset asserted between a fetch grant and the edge that would respond.
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
    #1 reset = 1'b1;
    #1;
    check_quiet("midreset");
    if_q.delete();
    d_q.delete();
    starve_m = 0;
    @(negedge clk);
    reset = 1'b0;
    bus.if_req_valid = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
